reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station_if.sv | 31 +++
 rtl/reservation_station.sv | 90 +++++++++
 tb/tb_reservation_station.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/reservation_station_if.sv
// reservation_station_if: dispatch, CDB, flush and issue signals of the reservation station.
interface reservation_station_if #(
   parameter int XLEN = 32,
   parameter int ROB_TAG_LEN = 3,
   parameter int FUNC_LEN = 5
);
   logic load;
   logic [FUNC_LEN-1:0] func;
   logic [ROB_TAG_LEN-1:0] tag_dest, tag_src1, tag_src2;
   logic ready_src1, ready_src2;
   logic [XLEN-1:0] value_src1, value_src2;
   logic full;
   logic cdb_valid;
   logic [ROB_TAG_LEN-1:0] cdb_tag;
   logic [XLEN-1:0] cdb_value;
   logic flush;
   logic issue_valid, issue_ready;
   logic [FUNC_LEN-1:0] issue_func;
   logic [ROB_TAG_LEN-1:0] issue_tag_dest;
   logic [XLEN-1:0] issue_src1, issue_src2;
   modport master (
      output load, func, tag_dest, tag_src1, tag_src2, ready_src1, ready_src2,
             value_src1, value_src2, cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
      input  full, issue_valid, issue_func, issue_tag_dest, issue_src1, issue_src2
   );
   modport slave (
      input  load, func, tag_dest, tag_src1, tag_src2, ready_src1, ready_src2,
             value_src1, value_src2, cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
      output full, issue_valid, issue_func, issue_tag_dest, issue_src1, issue_src2
   );
endinterface

// File: rtl/reservation_station.sv
// reservation_station: operand-capturing RS with CDB wakeup and lowest-index issue select.
// Define RS_CDB_BYPASS_EN to let an entry issue in the same cycle its last operand is broadcast.
module reservation_station #(
   parameter int RS_SIZE = 4,
   parameter int XLEN = 32,
   parameter int ROB_TAG_LEN = 3,
   parameter int FUNC_LEN = 5
) (
   input logic clk,
   input logic reset,
   reservation_station_if.slave rs
);
   localparam int IW = $clog2(RS_SIZE);
   logic [RS_SIZE-1:0] valid, rdy1, rdy2, m1, m2, can_issue;
   logic [FUNC_LEN-1:0] func_q [RS_SIZE];
   logic [ROB_TAG_LEN-1:0] tag_dest_q [RS_SIZE];
   logic [ROB_TAG_LEN-1:0] tag1 [RS_SIZE];
   logic [ROB_TAG_LEN-1:0] tag2 [RS_SIZE];
   logic [XLEN-1:0] val1 [RS_SIZE];
   logic [XLEN-1:0] val2 [RS_SIZE];
   logic [IW-1:0] free_idx, sel_idx;
   logic lm1, lm2, take;
   for (genvar e = 0; e < RS_SIZE; e++) begin : g_ent
      assign m1[e] = rs.cdb_valid && tag1[e] == rs.cdb_tag;
      assign m2[e] = rs.cdb_valid && tag2[e] == rs.cdb_tag;
`ifdef RS_CDB_BYPASS_EN
      assign can_issue[e] = valid[e] && ((rdy1[e] && rdy2[e]) || (rdy1[e] && m2[e]) || (rdy2[e] && m1[e]));
`else
      assign can_issue[e] = valid[e] && rdy1[e] && rdy2[e];
`endif
   end
   always_comb begin
      free_idx = '0;
      sel_idx = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (!valid[i]) free_idx = IW'(i);
         if (can_issue[i]) sel_idx = IW'(i);
      end
   end
   // full reflects registered state only, so a slot freed by this cycle's issue is not reusable yet
   assign rs.full = &valid;
   assign rs.issue_valid = |can_issue && !rs.flush;
   assign take = rs.issue_valid && rs.issue_ready;
   assign rs.issue_func = rs.issue_valid ? func_q[sel_idx] : '0;
   assign rs.issue_tag_dest = rs.issue_valid ? tag_dest_q[sel_idx] : '0;
   assign rs.issue_src1 = !rs.issue_valid ? '0 : rdy1[sel_idx] ? val1[sel_idx] : rs.cdb_value;
   assign rs.issue_src2 = !rs.issue_valid ? '0 : rdy2[sel_idx] ? val2[sel_idx] : rs.cdb_value;
   assign lm1 = !rs.ready_src1 && rs.cdb_valid && rs.tag_src1 == rs.cdb_tag;
   assign lm2 = !rs.ready_src2 && rs.cdb_valid && rs.tag_src2 == rs.cdb_tag;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= '0;
         rdy1 <= '0;
         rdy2 <= '0;
         for (int i = 0; i < RS_SIZE; i++) begin
            func_q[i] <= '0;
            tag_dest_q[i] <= '0;
            tag1[i] <= '0;
            tag2[i] <= '0;
            val1[i] <= '0;
            val2[i] <= '0;
         end
      end else if (rs.flush) begin
         valid <= '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (valid[i] && !rdy1[i] && m1[i]) begin
               rdy1[i] <= 1'b1;
               val1[i] <= rs.cdb_value;
            end
            if (valid[i] && !rdy2[i] && m2[i]) begin
               rdy2[i] <= 1'b1;
               val2[i] <= rs.cdb_value;
            end
         end
         if (take) valid[sel_idx] <= 1'b0;
         if (rs.load && !rs.full) begin
            valid[free_idx] <= 1'b1;
            func_q[free_idx] <= rs.func;
            tag_dest_q[free_idx] <= rs.tag_dest;
            tag1[free_idx] <= rs.tag_src1;
            tag2[free_idx] <= rs.tag_src2;
            rdy1[free_idx] <= rs.ready_src1 || lm1;
            rdy2[free_idx] <= rs.ready_src2 || lm2;
            val1[free_idx] <= lm1 ? rs.cdb_value : rs.value_src1;
            val2[free_idx] <= lm2 ? rs.cdb_value : rs.value_src2;
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scoreboard bench for reservation_station (RS_SIZE=4).
module tb_reservation_station;
   localparam int XLEN = 32;
   localparam int TL = 3;
   localparam int FL = 5;
   typedef struct packed {
      logic [FL-1:0] func;
      logic [TL-1:0] tag;
      logic [XLEN-1:0] s1;
      logic [XLEN-1:0] s2;
   } item_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int n_cmp = 0;
   int n_err = 0;
   item_t sb[$];
   item_t want;
   reservation_station_if #(.XLEN(XLEN), .ROB_TAG_LEN(TL), .FUNC_LEN(FL)) rs ();
   reservation_station #(.RS_SIZE(4), .XLEN(XLEN), .ROB_TAG_LEN(TL), .FUNC_LEN(FL)) dut (
      .clk(clk),
      .reset(reset),
      .rs(rs)
   );
   always #5 clk = ~clk;
   function automatic item_t cur();
      return {rs.issue_func, rs.issue_tag_dest, rs.issue_src1, rs.issue_src2};
   endfunction
   task automatic chk(input string name, input logic [71:0] obs, input logic [71:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp_v);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      rs.load = 0; rs.func = '0; rs.tag_dest = '0;
      rs.tag_src1 = '0; rs.tag_src2 = '0; rs.ready_src1 = 0; rs.ready_src2 = 0;
      rs.value_src1 = '0; rs.value_src2 = '0;
      rs.cdb_valid = 0; rs.cdb_tag = '0; rs.cdb_value = '0;
      rs.flush = 0; rs.issue_ready = 0;
   endtask
   task automatic drive_ld(input logic [FL-1:0] f, input logic [TL-1:0] td,
                           input logic r1, input logic [TL-1:0] t1, input logic [XLEN-1:0] v1,
                           input logic r2, input logic [TL-1:0] t2, input logic [XLEN-1:0] v2);
      rs.load = 1; rs.func = f; rs.tag_dest = td;
      rs.ready_src1 = r1; rs.tag_src1 = t1; rs.value_src1 = v1;
      rs.ready_src2 = r2; rs.tag_src2 = t2; rs.value_src2 = v2;
   endtask
   task automatic ld_ready(input logic [FL-1:0] f, input logic [TL-1:0] td,
                           input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2);
      drive_ld(f, td, 1, '0, v1, 1, '0, v2);
      sb.push_back({f, td, v1, v2});
      tick();
      rs.load = 0;
   endtask
   task automatic pop_cmp(input string name);
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed %0h expected scoreboard entry (queue empty)", name, cur());
      end else begin
         want = sb.pop_front();
         chk(name, cur(), want);
      end
   endtask
   task automatic take(input string name);
      rs.issue_ready = 1;
      #1;
      chk({name, "_valid"}, 72'(rs.issue_valid), 72'(1));
      pop_cmp(name);
      tick();
      rs.issue_ready = 0;
   endtask
   initial begin
      idle();
      #12;
      chk("rst_full", 72'(rs.full), 72'(0));
      chk("rst_issue_valid", 72'(rs.issue_valid), 72'(0));
      chk("rst_issue_data", cur(), '0);
      tick();
      reset = 1;
      #1;
      chk("post_rst_full", 72'(rs.full), 72'(0));
      chk("post_rst_issue_valid", 72'(rs.issue_valid), 72'(0));
      tick();
      // fill to full with issue held off, then a fifth load must be dropped
      for (int i = 0; i < 4; i++) begin
         ld_ready(FL'(i + 1), TL'(i), 32'h100 + i, 32'h200 + i);
         chk("full_fill", 72'(rs.full), 72'(i == 3));
      end
      drive_ld(5'h1F, 3'd7, 1, '0, 32'hF00D, 1, '0, 32'hF00D);
      tick();
      rs.load = 0;
      chk("full_hold", 72'(rs.full), 72'(1));
      chk("func_entry0", 72'(rs.issue_func), 72'(1));
      repeat (3) tick();
      chk("stall_tag", 72'(rs.issue_tag_dest), 72'(0));
      repeat (4) take("drain_fill");
      chk("drained_valid", 72'(rs.issue_valid), 72'(0));
      chk("drained_data", cur(), '0);
      chk("drained_full", 72'(rs.full), 72'(0));
      // wakeup from CDB one cycle after load
      drive_ld(5'd5, 3'd1, 0, 3'd3, 32'h0, 1, '0, 32'h7);
      sb.push_back({5'd5, 3'd1, 32'hDEADBEEF, 32'h7});
      tick();
      idle();
      #1;
      chk("wait_cdb", 72'(rs.issue_valid), 72'(0));
      rs.cdb_valid = 1; rs.cdb_tag = 3'd3; rs.cdb_value = 32'hDEADBEEF;
      #1;
`ifdef RS_CDB_BYPASS_EN
      chk("bypass_valid", 72'(rs.issue_valid), 72'(1));
      chk("bypass_src1", 72'(rs.issue_src1), 72'(32'hDEADBEEF));
      take("bypass_issue");
      rs.cdb_valid = 0;
`else
      chk("no_bypass", 72'(rs.issue_valid), 72'(0));
      tick();
      rs.cdb_valid = 0;
      take("woken_issue");
`endif
      // operand captured from CDB during load
      rs.cdb_valid = 1; rs.cdb_tag = 3'd5; rs.cdb_value = 32'h12;
      drive_ld(5'd7, 3'd2, 1, '0, 32'h55, 0, 3'd5, 32'h99);
      sb.push_back({5'd7, 3'd2, 32'h55, 32'h12});
      #1;
      chk("load_cap_empty", 72'(rs.issue_valid), 72'(0));
      tick();
      idle();
      take("load_capture");
      // one broadcast wakes two waiting entries
      drive_ld(5'd3, 3'd4, 0, 3'd6, 32'h0, 1, '0, 32'hA1);
      sb.push_back({5'd3, 3'd4, 32'h66, 32'hA1});
      tick();
      drive_ld(5'd4, 3'd5, 1, '0, 32'hB2, 0, 3'd6, 32'h0);
      sb.push_back({5'd4, 3'd5, 32'hB2, 32'h66});
      tick();
      idle();
      rs.cdb_valid = 1; rs.cdb_tag = 3'd6; rs.cdb_value = 32'h66;
      tick();
      rs.cdb_valid = 0;
      take("multi_wake_a");
      take("multi_wake_b");
      // random ready ops
      for (int i = 0; i < 6; i++) begin
         ld_ready(FL'($urandom_range(0, 31)), TL'($urandom_range(0, 7)), $urandom, $urandom);
         take("rand_op");
      end
      // full + accept + load in one cycle: load dropped, three entries remain
      for (int i = 0; i < 4; i++) ld_ready(FL'(8 + i), TL'(i), 32'h300 + i, 32'h400 + i);
      chk("full_again", 72'(rs.full), 72'(1));
      rs.issue_ready = 1;
      drive_ld(5'h1E, 3'd7, 1, '0, 32'hAAAA, 1, '0, 32'hBBBB);
      #1;
      chk("full_same_cycle", 72'(rs.full), 72'(1));
      chk("hs_valid", 72'(rs.issue_valid), 72'(1));
      pop_cmp("hs_issue");
      tick();
      idle();
      chk("full_freed", 72'(rs.full), 72'(0));
      repeat (3) take("drain3");
      #1;
      chk("count3", 72'(rs.issue_valid), 72'(0));
      // flush overrides load and issue
      for (int i = 0; i < 3; i++) ld_ready(FL'(20 + i), TL'(i), 32'h500 + i, 32'h600 + i);
      rs.flush = 1;
      rs.issue_ready = 1;
      drive_ld(5'd9, 3'd3, 1, '0, 32'h1, 1, '0, 32'h2);
      #1;
      chk("flush_iv", 72'(rs.issue_valid), 72'(0));
      chk("flush_data", cur(), '0);
      tick();
      idle();
      sb.delete();
      chk("flush_clear_iv", 72'(rs.issue_valid), 72'(0));
      chk("flush_clear_full", 72'(rs.full), 72'(0));
      tick();
      chk("flush_stay", 72'(rs.issue_valid), 72'(0));
      ld_ready(5'd11, 3'd6, 32'hC0FFEE, 32'h1234);
      take("post_flush");
      // reset mid-stream discards pending entries
      ld_ready(5'd12, 3'd1, 32'h77, 32'h88);
      ld_ready(5'd13, 3'd2, 32'h99, 32'hAA);
      chk("pre_reset_iv", 72'(rs.issue_valid), 72'(1));
      reset = 0;
      #1;
      chk("mid_rst_iv", 72'(rs.issue_valid), 72'(0));
      chk("mid_rst_full", 72'(rs.full), 72'(0));
      chk("mid_rst_data", cur(), '0);
      tick();
      reset = 1;
      sb.delete();
      rs.issue_ready = 1;
      repeat (3) begin
         #1;
         chk("after_rst_iv", 72'(rs.issue_valid), 72'(0));
         tick();
      end
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
